// File: rtl/wave_capture_pkg.sv
// Shared constants and FSM encoding for the wave capture stage.
package wave_capture_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int PIX_W      = 8;
    localparam int DEPTH_LOG2 = 8;
    localparam int ADDR_W     = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/wave_capture_zero_cross_detect.sv
// Remembers the previous audio sample and flags a negative-to-non-negative transition.
module zero_cross_detect
    import wave_capture_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                pos_cross
);

    logic [SAMPLE_W-1:0] prev_q;
    logic [SAMPLE_W-1:0] prev_d;
    logic                unused_prev_low;

    // NOTE: every variable assigned in always_comb gets a value on every path, or a latch is inferred.
    always_comb begin
        prev_d = prev_q;
        if (sample_valid) begin
            prev_d = sample;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pos_cross = sample_valid && prev_q[SAMPLE_W-1] && !sample[SAMPLE_W-1];

    // Only the sign of the previous sample matters for crossing detection.
    assign unused_prev_low = ^prev_q[SAMPLE_W-2:0];

endmodule

// File: rtl/wave_capture.sv
// Triggered capture of 256 display samples into the RAM half the display is not reading.
module wave_capture
    import wave_capture_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [ADDR_W-1:0]   write_address,
    output logic                write_enable,
    output logic [PIX_W-1:0]    write_sample,
    output logic                read_index
);

    state_e                state_q;
    state_e                state_d;
    logic [DEPTH_LOG2-1:0] count_q;
    logic [DEPTH_LOG2-1:0] count_d;
    logic                  read_index_q;
    logic                  read_index_d;
    logic                  write_enable_q;
    logic                  write_enable_d;
    logic [ADDR_W-1:0]     write_address_q;
    logic [ADDR_W-1:0]     write_address_d;
    logic [PIX_W-1:0]      write_sample_q;
    logic [PIX_W-1:0]      write_sample_d;
    logic                  pos_cross;

    zero_cross_detect u_zero_cross_detect (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (new_sample_ready),
        .sample       (new_sample_in),
        .pos_cross    (pos_cross)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        read_index_d = read_index_q;
        case (state_q)
            ARMED: begin
                if (pos_cross) begin
                    state_d = ACTIVE;
                    count_d = DEPTH_LOG2'(1);
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    count_d = count_q + DEPTH_LOG2'(1);
                    if (count_q == '1) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    // count_q is always 0 in ARMED, so the crossing sample lands at offset 0.
    always_comb begin
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;
        if ((state_q == ARMED && pos_cross) || (state_q == ACTIVE && new_sample_ready)) begin
            write_enable_d  = 1'b1;
            write_address_d = {~read_index_q, count_q};
            write_sample_d  = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: PIX_W-1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q         <= '0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            count_q         <= count_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
        end
    end

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule
